// File: rtl/packet_dest_demux_pkg.sv
// Shared network definitions: port count, packet field widths and the packed packet type.
// Used by the destination demux and the arbiter.
package packet_dest_demux_pkg;

    localparam int NUM_OUT = 5;
    localparam int SRC_W   = 3;
    localparam int DST_W   = 3;
    localparam int ADDR_W  = 26;
    localparam int PTYPE_W = 2;
    localparam int PKT_W   = SRC_W + DST_W + ADDR_W + PTYPE_W;

    typedef struct packed {
        logic [SRC_W-1:0]   src;
        logic [DST_W-1:0]   dst;
        logic [ADDR_W-1:0]  addr_block;
        logic [PTYPE_W-1:0] p_type;
    } pkt_t;

    function automatic logic dst_is_valid(input logic [DST_W-1:0] dst, input int num_out);
        return int'(dst) < num_out;
    endfunction

endpackage

// File: rtl/packet_dest_demux_queue.sv
// packet_queue: QDEPTH-entry valid/ready FIFO with registered occupancy.
// Enqueue is blocked when full even if a dequeue happens in the same cycle.
module packet_queue
    import packet_dest_demux_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int DATA_W = PKT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [DATA_W-1:0] enq_data,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [DATA_W-1:0] deq_data
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);

    logic [DATA_W-1:0] mem [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign enq_ready = ~full;
    assign deq_valid = ~empty;
    assign push      = enq_valid & ~full;
    assign pop       = deq_ready & ~empty;
    assign deq_data  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; validity comes from the reset pointers/count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/packet_dest_demux.sv
// packet_dest_demux: steers each input packet to the queue selected by its dst field;
// packets with an out-of-range dst are accepted, discarded and counted.
module packet_dest_demux #(
    parameter int NUM_OUT = packet_dest_demux_pkg::NUM_OUT,
    parameter int QDEPTH  = 2,
    parameter int DROP_W  = 8
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     io_in_valid,
    output logic                                     io_in_ready,
    input  logic [packet_dest_demux_pkg::SRC_W-1:0]   io_in_bits_header_src,
    input  logic [packet_dest_demux_pkg::DST_W-1:0]   io_in_bits_header_dst,
    input  logic [packet_dest_demux_pkg::ADDR_W-1:0]  io_in_bits_payload_addr_block,
    input  logic [packet_dest_demux_pkg::PTYPE_W-1:0] io_in_bits_payload_p_type,
    output logic                                     io_out_0_valid,
    input  logic                                     io_out_0_ready,
    output logic [packet_dest_demux_pkg::SRC_W-1:0]   io_out_0_bits_header_src,
    output logic [packet_dest_demux_pkg::DST_W-1:0]   io_out_0_bits_header_dst,
    output logic [packet_dest_demux_pkg::ADDR_W-1:0]  io_out_0_bits_payload_addr_block,
    output logic [packet_dest_demux_pkg::PTYPE_W-1:0] io_out_0_bits_payload_p_type,
    output logic                                     io_out_1_valid,
    input  logic                                     io_out_1_ready,
    output logic [packet_dest_demux_pkg::SRC_W-1:0]   io_out_1_bits_header_src,
    output logic [packet_dest_demux_pkg::DST_W-1:0]   io_out_1_bits_header_dst,
    output logic [packet_dest_demux_pkg::ADDR_W-1:0]  io_out_1_bits_payload_addr_block,
    output logic [packet_dest_demux_pkg::PTYPE_W-1:0] io_out_1_bits_payload_p_type,
    output logic                                     io_out_2_valid,
    input  logic                                     io_out_2_ready,
    output logic [packet_dest_demux_pkg::SRC_W-1:0]   io_out_2_bits_header_src,
    output logic [packet_dest_demux_pkg::DST_W-1:0]   io_out_2_bits_header_dst,
    output logic [packet_dest_demux_pkg::ADDR_W-1:0]  io_out_2_bits_payload_addr_block,
    output logic [packet_dest_demux_pkg::PTYPE_W-1:0] io_out_2_bits_payload_p_type,
    output logic                                     io_out_3_valid,
    input  logic                                     io_out_3_ready,
    output logic [packet_dest_demux_pkg::SRC_W-1:0]   io_out_3_bits_header_src,
    output logic [packet_dest_demux_pkg::DST_W-1:0]   io_out_3_bits_header_dst,
    output logic [packet_dest_demux_pkg::ADDR_W-1:0]  io_out_3_bits_payload_addr_block,
    output logic [packet_dest_demux_pkg::PTYPE_W-1:0] io_out_3_bits_payload_p_type,
    output logic                                     io_out_4_valid,
    input  logic                                     io_out_4_ready,
    output logic [packet_dest_demux_pkg::SRC_W-1:0]   io_out_4_bits_header_src,
    output logic [packet_dest_demux_pkg::DST_W-1:0]   io_out_4_bits_header_dst,
    output logic [packet_dest_demux_pkg::ADDR_W-1:0]  io_out_4_bits_payload_addr_block,
    output logic [packet_dest_demux_pkg::PTYPE_W-1:0] io_out_4_bits_payload_p_type,
    output logic                                     io_drop,
    output logic [DROP_W-1:0]                        io_drop_count
);

    import packet_dest_demux_pkg::*;

    // Five physical output ports exist; NUM_OUT selects how many are populated.
    localparam int MAX_OUT = 5;
    localparam int NUM_Q   = (NUM_OUT < MAX_OUT) ? NUM_OUT : MAX_OUT;

    pkt_t               in_pkt;
    logic               dst_ok;
    logic [MAX_OUT-1:0] enq_valid;
    logic [MAX_OUT-1:0] q_rdy;
    logic [MAX_OUT-1:0] out_valid;
    logic [MAX_OUT-1:0] out_ready;
    pkt_t               out_pkt [MAX_OUT];
    logic               drop_p0;
    logic               drop_vld_p1;
    logic [DROP_W-1:0]  drop_cnt_p1;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_pkt = '{src:        io_in_bits_header_src,
                      dst:        io_in_bits_header_dst,
                      addr_block: io_in_bits_payload_addr_block,
                      p_type:     io_in_bits_payload_p_type};

    assign dst_ok = dst_is_valid(io_in_bits_header_dst, NUM_Q);

    // Ready depends only on the addressed queue, never on downstream ready.
    always_comb begin
        io_in_ready = 1'b1;
        enq_valid   = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            if (dst_ok && (int'(io_in_bits_header_dst) == k)) begin
                io_in_ready  = q_rdy[k];
                enq_valid[k] = io_in_valid;
            end
        end
    end

    assign out_ready = {io_out_4_ready, io_out_3_ready, io_out_2_ready,
                        io_out_1_ready, io_out_0_ready};

    for (genvar k = 0; k < MAX_OUT; k++) begin : g_out
        if (k < NUM_Q) begin : g_q
            packet_queue #(
                .QDEPTH (QDEPTH),
                .DATA_W (PKT_W)
            ) u_q (
                .clk       (clk),
                .reset     (reset),
                .enq_valid (enq_valid[k]),
                .enq_ready (q_rdy[k]),
                .enq_data  (in_pkt),
                .deq_valid (out_valid[k]),
                .deq_ready (out_ready[k]),
                .deq_data  (out_pkt[k])
            );
        end else begin : g_idle
            assign q_rdy[k]     = 1'b1;
            assign out_valid[k] = 1'b0;
            assign out_pkt[k]   = '0;
        end
    end

    // Drop stage: the pulse and count update land one cycle after acceptance.
    assign drop_p0 = io_in_valid & ~dst_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_vld_p1 <= 1'b0;
            drop_cnt_p1 <= '0;
        end else begin
            drop_vld_p1 <= drop_p0;
            if (drop_p0) drop_cnt_p1 <= sat_inc(drop_cnt_p1);
        end
    end

    assign io_drop       = drop_vld_p1;
    assign io_drop_count = drop_cnt_p1;

    assign io_out_0_valid                   = out_valid[0];
    assign io_out_0_bits_header_src         = out_pkt[0].src;
    assign io_out_0_bits_header_dst         = out_pkt[0].dst;
    assign io_out_0_bits_payload_addr_block = out_pkt[0].addr_block;
    assign io_out_0_bits_payload_p_type     = out_pkt[0].p_type;

    assign io_out_1_valid                   = out_valid[1];
    assign io_out_1_bits_header_src         = out_pkt[1].src;
    assign io_out_1_bits_header_dst         = out_pkt[1].dst;
    assign io_out_1_bits_payload_addr_block = out_pkt[1].addr_block;
    assign io_out_1_bits_payload_p_type     = out_pkt[1].p_type;

    assign io_out_2_valid                   = out_valid[2];
    assign io_out_2_bits_header_src         = out_pkt[2].src;
    assign io_out_2_bits_header_dst         = out_pkt[2].dst;
    assign io_out_2_bits_payload_addr_block = out_pkt[2].addr_block;
    assign io_out_2_bits_payload_p_type     = out_pkt[2].p_type;

    assign io_out_3_valid                   = out_valid[3];
    assign io_out_3_bits_header_src         = out_pkt[3].src;
    assign io_out_3_bits_header_dst         = out_pkt[3].dst;
    assign io_out_3_bits_payload_addr_block = out_pkt[3].addr_block;
    assign io_out_3_bits_payload_p_type     = out_pkt[3].p_type;

    assign io_out_4_valid                   = out_valid[4];
    assign io_out_4_bits_header_src         = out_pkt[4].src;
    assign io_out_4_bits_header_dst         = out_pkt[4].dst;
    assign io_out_4_bits_payload_addr_block = out_pkt[4].addr_block;
    assign io_out_4_bits_payload_p_type     = out_pkt[4].p_type;

endmodule

// File: tb/tb_packet_dest_demux.sv
// Directed bench for packet_dest_demux with a per-output scoreboard of expected packets.
module tb_packet_dest_demux;
    import packet_dest_demux_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    pkt_t       in_pkt = '0;
    logic [4:0] out_ready = 5'b11111;
    logic [4:0] out_valid;
    pkt_t       out_pkt [5];
    logic       drop;
    logic [7:0] drop_count;

    int         tests = 0;
    int         failed = 0;
    pkt_t       sbq [5][$];
    logic       exp_drop = 1'b0;
    logic [7:0] exp_cnt = 8'd0;
    logic       acc;
    int         n;
    pkt_t       pa, pb, pc, p1, p2;

    always #5 clk = ~clk;

    packet_dest_demux dut (
        .clk                              (clk),
        .reset                            (reset),
        .io_in_valid                      (in_valid),
        .io_in_ready                      (in_ready),
        .io_in_bits_header_src            (in_pkt.src),
        .io_in_bits_header_dst            (in_pkt.dst),
        .io_in_bits_payload_addr_block    (in_pkt.addr_block),
        .io_in_bits_payload_p_type        (in_pkt.p_type),
        .io_out_0_valid                   (out_valid[0]),
        .io_out_0_ready                   (out_ready[0]),
        .io_out_0_bits_header_src         (out_pkt[0].src),
        .io_out_0_bits_header_dst         (out_pkt[0].dst),
        .io_out_0_bits_payload_addr_block (out_pkt[0].addr_block),
        .io_out_0_bits_payload_p_type     (out_pkt[0].p_type),
        .io_out_1_valid                   (out_valid[1]),
        .io_out_1_ready                   (out_ready[1]),
        .io_out_1_bits_header_src         (out_pkt[1].src),
        .io_out_1_bits_header_dst         (out_pkt[1].dst),
        .io_out_1_bits_payload_addr_block (out_pkt[1].addr_block),
        .io_out_1_bits_payload_p_type     (out_pkt[1].p_type),
        .io_out_2_valid                   (out_valid[2]),
        .io_out_2_ready                   (out_ready[2]),
        .io_out_2_bits_header_src         (out_pkt[2].src),
        .io_out_2_bits_header_dst         (out_pkt[2].dst),
        .io_out_2_bits_payload_addr_block (out_pkt[2].addr_block),
        .io_out_2_bits_payload_p_type     (out_pkt[2].p_type),
        .io_out_3_valid                   (out_valid[3]),
        .io_out_3_ready                   (out_ready[3]),
        .io_out_3_bits_header_src         (out_pkt[3].src),
        .io_out_3_bits_header_dst         (out_pkt[3].dst),
        .io_out_3_bits_payload_addr_block (out_pkt[3].addr_block),
        .io_out_3_bits_payload_p_type     (out_pkt[3].p_type),
        .io_out_4_valid                   (out_valid[4]),
        .io_out_4_ready                   (out_ready[4]),
        .io_out_4_bits_header_src         (out_pkt[4].src),
        .io_out_4_bits_header_dst         (out_pkt[4].dst),
        .io_out_4_bits_payload_addr_block (out_pkt[4].addr_block),
        .io_out_4_bits_payload_p_type     (out_pkt[4].p_type),
        .io_drop                          (drop),
        .io_drop_count                    (drop_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ready();
        if (in_pkt.dst < 3'd5) return sbq[in_pkt.dst].size() < 2;
        return 1'b1;
    endfunction

    // One clock: check DUT against the scoreboard, then record this cycle's handshakes.
    task automatic cycle(output logic accepted);
        logic next_drop;
        @(negedge clk);
        chk("io_drop", 64'(drop), 64'(exp_drop));
        chk("io_drop_count", 64'(drop_count), 64'(exp_cnt));
        chk("io_in_ready", 64'(in_ready), 64'(exp_ready()));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("out%0d_valid", k), 64'(out_valid[k]), 64'(sbq[k].size() != 0));
            if (out_valid[k] && sbq[k].size() != 0) begin
                chk($sformatf("out%0d_bits", k), 64'(out_pkt[k]), 64'(sbq[k][0]));
                if (out_ready[k]) void'(sbq[k].pop_front());
            end
        end
        accepted  = in_valid && in_ready;
        next_drop = 1'b0;
        if (accepted) begin
            if (in_pkt.dst < 3'd5) sbq[in_pkt.dst].push_back(in_pkt);
            else begin
                next_drop = 1'b1;
                if (exp_cnt != 8'hFF) exp_cnt++;
            end
        end
        @(posedge clk);
        #1;
        exp_drop = next_drop;
    endtask

    function automatic pkt_t mk(input logic [2:0] s, input logic [2:0] d,
                                input logic [25:0] a, input logic [1:0] p);
        return '{src: s, dst: d, addr_block: a, p_type: p};
    endfunction

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_drop", 64'(drop), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        cycle(acc);

        // Single packet to dst 3
        in_pkt   = mk(3'd1, 3'd3, 26'h155AAAA, 2'd2);
        in_valid = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        chk("single_acc", 64'(acc), 64'd1);
        chk("single_valid_vec", 64'(out_valid), 64'h08);
        chk("single_bits", 64'(out_pkt[3]), 64'(mk(3'd1, 3'd3, 26'h155AAAA, 2'd2)));
        cycle(acc);
        cycle(acc);

        // Backpressure on output 1
        out_ready = 5'b11101;
        pa = mk(3'd2, 3'd1, 26'h000000A, 2'd0);
        pb = mk(3'd3, 3'd1, 26'h000000B, 2'd1);
        pc = mk(3'd4, 3'd1, 26'h000000C, 2'd3);
        in_valid = 1'b1;
        in_pkt = pa; cycle(acc);
        in_pkt = pb; cycle(acc);
        in_pkt = pc; cycle(acc);
        chk("bp_third_stalled", 64'(acc), 64'd0);
        out_ready[1] = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 10) begin
            cycle(acc);
            n++;
        end
        chk("bp_third_accept_cycle", 64'(n), 64'd2);
        in_valid = 1'b0;
        repeat (3) cycle(acc);

        // Invalid destinations back-to-back
        in_valid = 1'b1;
        in_pkt = mk(3'd0, 3'd5, 26'h1, 2'd0); cycle(acc);
        in_pkt = mk(3'd0, 3'd6, 26'h2, 2'd1); cycle(acc);
        in_pkt = mk(3'd0, 3'd7, 26'h3, 2'd2); cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        chk("drop_count_3", 64'(drop_count), 64'd3);
        chk("drop_no_valid", 64'(out_valid), 64'd0);
        cycle(acc);

        // Drop counter saturation
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            in_pkt = mk(3'd5, 3'd7, 26'(i), 2'd3);
            cycle(acc);
        end
        in_valid = 1'b0;
        cycle(acc);
        chk("drop_count_sat", 64'(drop_count), 64'd255);
        cycle(acc);

        // Simultaneous push and pop on queue 0
        p1 = mk(3'd6, 3'd0, 26'h0ABCDEF, 2'd1);
        p2 = mk(3'd7, 3'd0, 26'h3012345, 2'd2);
        out_ready[0] = 1'b0;
        in_valid = 1'b1;
        in_pkt = p1; cycle(acc);
        in_pkt = p2; out_ready[0] = 1'b1; cycle(acc);
        chk("pp_accept", 64'(acc), 64'd1);
        in_valid = 1'b0;
        out_ready[0] = 1'b0;
        chk("pp_occupancy", 64'(dut.g_out[0].g_q.u_q.count), 64'd1);
        chk("pp_head", 64'(out_pkt[0]), 64'(p2));
        repeat (2) cycle(acc);
        out_ready[0] = 1'b1;
        repeat (2) cycle(acc);

        // Mid-operation reset with queues 2 and 4 full
        out_ready = 5'b01011;
        in_valid = 1'b1;
        in_pkt = mk(3'd1, 3'd2, 26'h2000001, 2'd0); cycle(acc);
        in_pkt = mk(3'd1, 3'd2, 26'h2000002, 2'd1); cycle(acc);
        in_pkt = mk(3'd1, 3'd4, 26'h4000001, 2'd2); cycle(acc);
        in_pkt = mk(3'd1, 3'd4, 26'h4000002, 2'd3); cycle(acc);
        in_pkt = mk(3'd1, 3'd6, 26'h0000066, 2'd0); cycle(acc);
        in_valid = 1'b0;
        chk("mr_full_valid", 64'(out_valid), 64'h14);
        reset = 1'b0;
        #1;
        chk("mr_valid_cleared", 64'(out_valid), 64'd0);
        chk("mr_drop_count", 64'(drop_count), 64'd0);
        chk("mr_drop", 64'(drop), 64'd0);
        for (int k = 0; k < 5; k++) sbq[k].delete();
        exp_cnt  = 8'd0;
        exp_drop = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 5'b11111;
        repeat (4) cycle(acc);
        in_valid = 1'b1;
        in_pkt = mk(3'd2, 3'd2, 26'h2ABCDEF, 2'd1); cycle(acc);
        in_valid = 1'b0;
        repeat (2) cycle(acc);

        // Mixed traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            in_valid          = 1'($urandom_range(0, 1));
            in_pkt.src        = 3'($urandom_range(0, 7));
            in_pkt.dst        = 3'($urandom_range(0, 7));
            in_pkt.addr_block = 26'($urandom());
            in_pkt.p_type     = 2'($urandom_range(0, 3));
            out_ready         = 5'($urandom());
            cycle(acc);
        end
        in_valid  = 1'b0;
        out_ready = 5'b11111;
        repeat (4) cycle(acc);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
